pump_sequencer: RTL and testbench



---
 rtl/pump_pkg.sv | 7 +
 rtl/sync_edge.sv | 20 ++
 rtl/pump_sequencer.sv | 102 ++++++++++
 tb/tb_pump_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pump_pkg.sv
// pump_pkg: shared state encoding and fault codes for the pump sequencer
package pump_pkg;
  typedef enum logic [2:0] {IDLE, PRIME, RUN, STOP, FAULT} state_t;
  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_DRY = 2'd1;
  localparam logic [1:0] FC_NOFLOW = 2'd2;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer with a registered rising-edge pulse
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [2:0] sr;
  assign level = sr[1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
      rise <= 1'b0;
    end else begin
      sr <= {sr[1:0], d};
      rise <= sr[1] & ~sr[2];
    end
  end
endmodule

// File: rtl/pump_sequencer.sv
// pump_sequencer: valve/pump sequencing with volume metering and dry/no-flow faults
module pump_sequencer
  import pump_pkg::*;
#(
  parameter int PRIME_CYCLES = 1000,
  parameter int STOP_CYCLES = 500,
  parameter int NOFLOW_CYCLES = 50000,
  parameter int VOL_W = 16,
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [VOL_W-1:0] target,
  input  logic             flow_in,
  input  logic             level_low,
  input  logic             fault_clr,
  output logic             pump_on,
  output logic             valve_open,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [VOL_W-1:0] vol_count
);
  state_t state, nxt;
  logic [TMR_W-1:0] timer;
  logic [VOL_W-1:0] tgt;
  logic [1:0] code_n;
  logic aborted, done_n, abort_n, flow_ev, low_s, hit;
  logic flow_level_unused, low_rise_unused;
  sync_edge u_flow (.clk(clk), .rst_n(rst_n), .d(flow_in), .level(flow_level_unused), .rise(flow_ev));
  sync_edge u_low (.clk(clk), .rst_n(rst_n), .d(level_low), .level(low_s), .rise(low_rise_unused));
  wire prime_end = timer == TMR_W'(PRIME_CYCLES - 1);
  wire stop_end = timer == TMR_W'(STOP_CYCLES - 1);
  // a pulse arriving on the last no-flow clock still counts as flow
  wire noflow_end = !flow_ev && timer == TMR_W'(NOFLOW_CYCLES - 1);
  assign hit = flow_ev && ({1'b0, vol_count} + 1'b1 == {1'b0, tgt});
  always_comb begin
    nxt = state;
    code_n = fault_code;
    done_n = 1'b0;
    abort_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        nxt = low_s ? FAULT : (target == '0 ? IDLE : PRIME);
        code_n = low_s ? FC_DRY : fault_code;
        done_n = !low_s && target == '0;
      end
      PRIME: begin
        nxt = low_s ? FAULT : stop ? IDLE : prime_end ? RUN : PRIME;
        code_n = low_s ? FC_DRY : fault_code;
      end
      RUN: begin
        nxt = low_s ? FAULT : (hit || stop) ? STOP : noflow_end ? FAULT : RUN;
        code_n = low_s ? FC_DRY : (!hit && !stop && noflow_end) ? FC_NOFLOW : fault_code;
        abort_n = !low_s && !hit && stop;
      end
      STOP: begin
        nxt = stop_end ? IDLE : STOP;
        done_n = stop_end && !aborted;
      end
      FAULT: begin
        nxt = fault_clr ? IDLE : FAULT;
        code_n = fault_clr ? FC_NONE : fault_code;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      tgt <= '0;
      vol_count <= '0;
      aborted <= 1'b0;
      fault_code <= FC_NONE;
      pump_on <= 1'b0;
      valve_open <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= nxt;
      fault_code <= code_n;
      done <= done_n;
      pump_on <= nxt == RUN;
      valve_open <= nxt inside {PRIME, RUN, STOP};
      busy <= nxt inside {PRIME, RUN, STOP};
      fault <= nxt == FAULT;
      timer <= (nxt != state || !busy || (state == RUN && flow_ev)) ? '0 : timer + 1'b1;
      if (state == IDLE && start && !low_s) begin
        tgt <= target;
        vol_count <= '0;
        aborted <= 1'b0;
      end else if (flow_ev && (state == RUN || state == STOP) && vol_count != '1)
        vol_count <= vol_count + 1'b1;
      if (abort_n) aborted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pump_sequencer.sv
// tb_pump_sequencer: randomized scoreboard bench for pump_sequencer
module tb_pump_sequencer;
  import pump_pkg::*;
  localparam int P = 4, S = 12, N = 20, VW = 5, TW = 8;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, flow_in = 0, level_low = 0, fault_clr = 0;
  logic [VW-1:0] target = '0;
  logic pump_on, valve_open, busy, done, fault;
  logic [1:0] fault_code;
  logic [VW-1:0] vol_count;
  pump_sequencer #(.PRIME_CYCLES(P), .STOP_CYCLES(S), .NOFLOW_CYCLES(N), .VOL_W(VW), .TMR_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .target(target), .flow_in(flow_in),
    .level_low(level_low), .fault_clr(fault_clr), .pump_on(pump_on), .valve_open(valve_open),
    .busy(busy), .done(done), .fault(fault), .fault_code(fault_code), .vol_count(vol_count));
  always #5 clk = ~clk;
  typedef struct {bit d; bit [1:0] c; int v;} ev_t;
  ev_t q[$];
  int total = 0, bad = 0, last_vol = 0;
  longint cyc = 0, vr = 0, pr = 0, pfall = 0;
  bit pv, pp, pb, pf, ran;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // monitor: one completion event per run (done, fault entry or leaving busy)
  always @(negedge clk) begin
    ev_t e;
    if (valve_open && !pv) vr = cyc;
    if (pump_on && !pp) begin
      chk("prime_len", cyc - vr, P);
      pr = cyc;
      ran = 1;
    end
    if (!pump_on && pp) pfall = cyc;
    if (fault && !pf && fault_code == FC_NOFLOW) chk("noflow_len", cyc - pr, N);
    if (pb && !busy && ran && pfall != cyc) chk("stop_len", cyc - pfall, S);
    if (done || (fault && !pf) || (pb && !busy)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: done=%0d code=%0d vol=%0d with nothing expected", done, fault_code, vol_count);
      end else begin
        e = q.pop_front();
        chk("done", done, e.d);
        chk("code", fault_code, e.c);
        chk("vol", vol_count, e.v);
        chk("pump_off", pump_on, 0);
        chk("valve_off", valve_open, 0);
      end
    end
    if (pb && !busy) ran = 0;
    pv = valve_open; pp = pump_on; pb = busy; pf = fault;
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(int hi, int lo);
    flow_in = 1; tick(hi);
    flow_in = 0; tick(lo);
  endtask
  task automatic rpulse();
    pulse($urandom_range(2, 4), $urandom_range(2, 4));
  endtask
  task automatic do_start(int t);
    target = VW'(t); start = 1; tick(1); start = 0;
  endtask
  task automatic wait_pump();
    int k = 0;
    while (!pump_on && k < 100) begin tick(1); k++; end
    if (!pump_on) begin total++; bad++; $display("FAIL wait_pump: timed out, pump_on=%0d expected 1", pump_on); end
  endtask
  task automatic wait_idle();
    int k = 0;
    tick(1);
    while (busy && k < 300) begin tick(1); k++; end
    if (busy) begin total++; bad++; $display("FAIL wait_idle: timed out, busy=%0d expected 0", busy); end
    tick(2);
  endtask
  task automatic clear_fault();
    level_low = 0; tick(3);
    fault_clr = 1; tick(1); fault_clr = 0;
    chk("clr_fault", fault, 0);
    chk("clr_code", fault_code, FC_NONE);
    tick(2);
  endtask
  task automatic normal_run(int t);
    q.push_back('{1, FC_NONE, t});
    do_start(t); wait_pump();
    repeat (t) rpulse();
    wait_idle();
    last_vol = t;
  endtask
  task automatic check_reset();
    chk("rst_pump", pump_on, 0); chk("rst_valve", valve_open, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_fault", fault, 0); chk("rst_code", fault_code, 0);
    chk("rst_vol", vol_count, 0);
  endtask
  initial begin
    int k;
    tick(3); rst_n = 1;
    check_reset();
    tick(2);
    normal_run(3);
    repeat (4) normal_run($urandom_range(1, 6));
    // abort in RUN after k pulses
    repeat (2) begin
      k = $urandom_range(1, 3);
      q.push_back('{0, FC_NONE, k});
      do_start(5); wait_pump();
      repeat (k) rpulse();
      stop = 1; tick(1); stop = 0;
      wait_idle();
      last_vol = k;
    end
    // abort in PRIME
    q.push_back('{0, FC_NONE, 0});
    do_start(3); tick(2);
    stop = 1; tick(1); stop = 0;
    wait_idle();
    last_vol = 0;
    // zero target completes immediately without opening the valve
    normal_run(2);
    q.push_back('{1, FC_NONE, 0});
    do_start(0); tick(3);
    last_vol = 0;
    // dry start, then start ignored while faulted
    normal_run(4);
    level_low = 1; tick(3);
    q.push_back('{0, FC_DRY, last_vol});
    do_start($urandom_range(1, 6)); tick(3);
    chk("dry_fault", fault, 1);
    do_start(2); tick(4);
    chk("fault_holds", fault, 1);
    chk("dry_code_held", fault_code, FC_DRY);
    clear_fault();
    // dry tank during RUN
    k = $urandom_range(0, 3);
    q.push_back('{0, FC_DRY, k});
    do_start(6); wait_pump();
    repeat (k) rpulse();
    level_low = 1;
    wait_idle();
    clear_fault();
    // no flow during RUN
    q.push_back('{0, FC_NOFLOW, 0});
    do_start(3); wait_pump();
    wait_idle();
    clear_fault();
    // saturation: overrun pulses in the run-down push past all-ones
    q.push_back('{1, FC_NONE, (1 << VW) - 1});
    do_start(30); wait_pump();
    repeat (32) pulse(2, 2);
    wait_idle();
    // reset mid-RUN, then a fresh run
    do_start(5); wait_pump(); rpulse();
    q.push_back('{0, FC_NONE, 0});
    rst_n = 0; tick(1); rst_n = 1;
    check_reset();
    tick(2);
    normal_run($urandom_range(1, 6));
    tick(5);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
